// File: rtl/rcu_seq_pkg.sv
// Shared definitions for the RCU clock sequencer: FSM states, mux select
// encoding and default timing parameters.
package rcu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_ON    = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SWITCH    = 3'd4,
        ST_RUN       = 3'd5,
        ST_STOP      = 3'd6,
        ST_FAULT     = 3'd7
    } state_e;

    localparam logic CLK_SEL_BYPASS = 1'b0;
    localparam logic CLK_SEL_PLL    = 1'b1;

    localparam int TMO_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 8;
    localparam int SWITCH_CYC_DEF = 4;

    // Sequencing is in progress everywhere except the three resting states.
    function automatic logic is_busy(input state_e st);
        logic b;
        case (st)
            ST_IDLE, ST_RUN, ST_FAULT: b = 1'b0;
            default:                   b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rcu_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module rcu_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rcu_clk_seq.sv
// PLL bring-up sequencer: enables the PLL, waits for a stable lock, switches
// the clock mux under peripheral reset, and falls back to bypass on loss/stop.
module rcu_clk_seq
    import rcu_seq_pkg::*;
#(
    parameter int TMO_W      = TMO_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int SWITCH_CYC = SWITCH_CYC_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             stop_i,
    input  logic             clr_i,
    input  logic [2:0]       cfg_i,
    input  logic [TMO_W-1:0] tmo_i,
    input  logic             lock_i,
    output logic             pll_en_o,
    output logic [2:0]       clk_cfg_o,
    output logic             clk_sel_o,
    output logic             periph_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [TMO_W-1:0] SETTLE_LOAD = TMO_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] SWITCH_LOAD = TMO_W'(SWITCH_CYC - 1);
    localparam logic [TMO_W-1:0] CNT_ONE     = TMO_W'(1);

    state_e           state;
    logic [TMO_W-1:0] cnt;
    logic             lock_s;

    rcu_sync2 u_lock_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (lock_i),
        .q   (lock_s)
    );

    assign busy_o = is_busy(state);

    // One counter serves the lock timeout, settle window and switch/stop holds;
    // it is only decremented while non-zero so it can never wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pll_en_o     <= 1'b0;
            clk_cfg_o    <= 3'b000;
            clk_sel_o    <= CLK_SEL_BYPASS;
            periph_rst_o <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        clk_cfg_o <= cfg_i;
                        cnt       <= tmo_i;
                        pll_en_o  <= 1'b1;
                        state     <= ST_PLL_ON;
                    end
                end
                ST_PLL_ON: begin
                    state <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so it wins on the final timeout cycle.
                    if (lock_s) begin
                        cnt   <= SETTLE_LOAD;
                        state <= ST_SETTLE;
                    end else if (cnt == '0) begin
                        pll_en_o <= 1'b0;
                        err_o    <= 1'b1;
                        state    <= ST_FAULT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        cnt   <= tmo_i;
                        state <= ST_WAIT_LOCK;
                    end else if (cnt == '0) begin
                        cnt          <= SWITCH_LOAD;
                        periph_rst_o <= 1'b1;
                        state        <= ST_SWITCH;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_SWITCH: begin
                    // The mux moves one cycle after peripheral reset is asserted.
                    clk_sel_o <= CLK_SEL_PLL;
                    if (cnt == '0) begin
                        periph_rst_o <= 1'b0;
                        done_o       <= 1'b1;
                        state        <= ST_RUN;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        periph_rst_o <= 1'b1;
                        clk_sel_o    <= CLK_SEL_BYPASS;
                        pll_en_o     <= 1'b0;
                        err_o        <= 1'b1;
                        state        <= ST_FAULT;
                    end else if (stop_i) begin
                        periph_rst_o <= 1'b1;
                        clk_sel_o    <= CLK_SEL_BYPASS;
                        cnt          <= SWITCH_LOAD;
                        state        <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt == '0) begin
                        pll_en_o <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_FAULT: begin
                    pll_en_o     <= 1'b0;
                    clk_sel_o    <= CLK_SEL_BYPASS;
                    periph_rst_o <= 1'b1;
                    err_o        <= 1'b1;
                    if (clr_i) begin
                        err_o <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcu_clk_seq.sv
// Bench for rcu_clk_seq: expected output timelines derived from the sequencing
// rules by edge arithmetic, compared every cycle.
module tb_rcu_clk_seq;

    localparam int TMO_W      = 16;
    localparam int SETTLE_CYC = 8;
    localparam int SWITCH_CYC = 4;
    localparam int MAXN       = 256;

    // {pll_en, clk_sel, periph_rst, busy, done, err}
    localparam logic [5:0] V_IDLE  = 6'b001000;
    localparam logic [5:0] V_SEQ   = 6'b101100;
    localparam logic [5:0] V_SW    = 6'b111100;
    localparam logic [5:0] V_DONE  = 6'b110010;
    localparam logic [5:0] V_RUN   = 6'b110000;
    localparam logic [5:0] V_FAULT = 6'b001001;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic             stop;
    logic             clr;
    logic [2:0]       cfg;
    logic [TMO_W-1:0] tmo;
    logic             lock;
    logic             pll_en;
    logic [2:0]       clk_cfg;
    logic             clk_sel;
    logic             periph_rst;
    logic             busy;
    logic             done;
    logic             err;

    rcu_clk_seq #(
        .TMO_W      (TMO_W),
        .SETTLE_CYC (SETTLE_CYC),
        .SWITCH_CYC (SWITCH_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .stop_i       (stop),
        .clr_i        (clr),
        .cfg_i        (cfg),
        .tmo_i        (tmo),
        .lock_i       (lock),
        .pll_en_o     (pll_en),
        .clk_cfg_o    (clk_cfg),
        .clk_sel_o    (clk_sel),
        .periph_rst_o (periph_rst),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    bit         req_sch  [MAXN];
    bit         lock_sch [MAXN];
    bit         stop_sch [MAXN];
    bit         clr_sch  [MAXN];
    logic [5:0] exp_v    [MAXN];
    logic [2:0] exp_cfg  [MAXN];

    function automatic logic [8:0] observed();
        return {pll_en, clk_sel, periph_rst, busy, done, err, clk_cfg};
    endfunction

    task automatic check(input string tag, input int n, input logic [8:0] obs, input logic [8:0] req_v);
        total++;
        assert (obs === req_v) passed++;
        else $error("FAIL %s edge=%0d observed=%b required=%b", tag, n, obs, req_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int n = 0; n < MAXN; n++) begin
            req_sch[n]  = 1'b0;
            lock_sch[n] = 1'b0;
            stop_sch[n] = 1'b0;
            clr_sch[n]  = 1'b0;
            exp_v[n]    = V_IDLE;
            exp_cfg[n]  = 3'b000;
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [5:0] v);
        for (int n = lo; n <= hi && n < MAXN; n++) exp_v[n] = v;
    endtask

    // Asynchronous reset: outputs must change before any clock edge.
    task automatic do_reset();
        #2;
        rst  = 1'b1;
        req  = 1'b0;
        stop = 1'b0;
        clr  = 1'b0;
        lock = 1'b0;
        #1;
        check("reset_async", 0, observed(), {V_IDLE, 3'b000});
        step();
        check("reset_hold", 0, observed(), {V_IDLE, 3'b000});
        rst = 1'b0;
    endtask

    // mode 0: stop from RUN; 1: lock loss in RUN; 2: lock loss with stop;
    // 3: one-cycle lock glitch after four settle cycles, then stop.
    task automatic plan_lock(input logic [2:0] c, input int t, input int l, input int mode,
                             input int k, output int e_w, output int last);
        int e_s;
        int e_r;
        int x;
        clear_plan();
        cfg = c;
        tmo = TMO_W'(t);
        req_sch[1] = 1'b1;
        for (int n = 1; n < MAXN; n++) exp_cfg[n] = c;
        for (int n = l; n < MAXN; n++) lock_sch[n] = 1'b1;
        e_s = (l + 2 > 3) ? l + 2 : 3;
        if (mode == 3) begin
            lock_sch[e_s + 3] = 1'b0;
            e_s = e_s + 6;
        end
        e_w = e_s + SETTLE_CYC;
        e_r = e_w + SWITCH_CYC;
        fill(1, e_w, V_SEQ);
        fill(e_w + 1, e_r - 1, V_SW);
        fill(e_r, e_r, V_DONE);
        fill(e_r + 1, MAXN - 1, V_RUN);
        x = e_r + k;
        if (mode == 1 || mode == 2) begin
            for (int n = x; n < MAXN; n++) lock_sch[n] = 1'b0;
            if (mode == 2) stop_sch[x + 2] = 1'b1;
            fill(x + 2, MAXN - 1, V_FAULT);
            req_sch[x + 4] = 1'b1;
            clr_sch[x + 6] = 1'b1;
            fill(x + 6, MAXN - 1, V_IDLE);
            last = x + 9;
        end else begin
            stop_sch[x] = 1'b1;
            fill(x, x + SWITCH_CYC - 1, V_SEQ);
            fill(x + SWITCH_CYC, MAXN - 1, V_IDLE);
            last = x + SWITCH_CYC + 3;
        end
    endtask

    // Lock never arrives: the window is tmo+1 WAIT_LOCK cycles after PLL_ON.
    task automatic plan_tmo(input logic [2:0] c, input int t, output int last);
        int f;
        clear_plan();
        cfg = c;
        tmo = TMO_W'(t);
        req_sch[1] = 1'b1;
        for (int n = 1; n < MAXN; n++) exp_cfg[n] = c;
        f = 3 + t;
        fill(1, f - 1, V_SEQ);
        fill(f, MAXN - 1, V_FAULT);
        req_sch[f + 2] = 1'b1;
        req_sch[f + 3] = 1'b1;
        clr_sch[f + 5] = 1'b1;
        clr_sch[f + 7] = 1'b1;
        fill(f + 5, MAXN - 1, V_IDLE);
        last = f + 9;
    endtask

    task automatic run(input string tag, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            req  = req_sch[n];
            lock = lock_sch[n];
            stop = stop_sch[n];
            clr  = clr_sch[n];
            step();
            check(tag, n, observed(), {exp_v[n], exp_cfg[n]});
        end
    endtask

    initial begin : main
        int ew;
        int last;
        int t;
        int l;
        int m;
        int k;
        logic [2:0] c;
        rst  = 1'b1;
        req  = 1'b0;
        stop = 1'b0;
        clr  = 1'b0;
        lock = 1'b0;
        cfg  = 3'b000;
        tmo  = '0;
        do_reset();

        plan_lock(3'b011, 100, 11, 0, 3, ew, last);
        run("lock_path", 1, last);

        do_reset();
        plan_tmo(3'b110, 20, last);
        run("timeout_20", 1, last);

        do_reset();
        plan_tmo(3'b001, 0, last);
        run("timeout_0", 1, last);

        do_reset();
        plan_lock(3'b100, 0, 1, 0, 2, ew, last);
        run("tmo0_lock", 1, last);

        do_reset();
        plan_lock(3'b111, 5, 6, 0, 2, ew, last);
        run("lock_wins_zero", 1, last);

        do_reset();
        plan_lock(3'b010, 30, 4, 1, 3, ew, last);
        run("lock_loss", 1, last);

        do_reset();
        plan_lock(3'b011, 30, 4, 2, 3, ew, last);
        run("loss_with_stop", 1, last);

        do_reset();
        plan_lock(3'b001, 40, 3, 3, 2, ew, last);
        run("settle_glitch", 1, last);

        do_reset();
        plan_lock(3'b010, 10, 2, 0, 3, ew, last);
        run("pre_reset", 1, ew + 2);
        do_reset();
        lock = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            check("idle_after_reset", n, observed(), {V_IDLE, 3'b000});
        end
        plan_lock(3'b101, 10, 1, 0, 3, ew, last);
        run("post_reset", 1, last);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            c = 3'($urandom_range(0, 7));
            t = int'($urandom_range(0, 60));
            l = int'($urandom_range(1, t + 1));
            m = int'($urandom_range(0, 3));
            k = int'($urandom_range(2, 6));
            plan_lock(c, t, l, m, k, ew, last);
            run("random_lock", 1, last);
            do_reset();
            plan_tmo(c, int'($urandom_range(0, 40)), last);
            run("random_tmo", 1, last);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
